wallace_unsigned_multiplier_rca_4: RTL and testbench

- 4x4-bit unsigned multiplier producing the full 8-bit product.
- Partial products are reduced with a Wallace tree of half/full adders to two rows; a ripple-carry adder (RCA) resolves the final sum.
- The result is captured in an output register, so the block sits as a single-cycle-latency arithmetic stage in a clocked datapath.

---
 rtl/wallace_unsigned_multiplier_rca_4_pkg.sv | 9 +
 rtl/wallace_unsigned_multiplier_rca_4_full_adder.sv | 16 +
 rtl/wallace_unsigned_multiplier_rca_4.sv | 145 ++++++++++++++
 tb/tb_wallace_unsigned_multiplier_rca_4.sv | 132 +++++++++++++
 4 files changed

// File: rtl/wallace_unsigned_multiplier_rca_4_pkg.sv
// Shared widths for the 4x4 Wallace-tree multiplier.
package wallace_unsigned_multiplier_rca_4_pkg;

    // Operand width (A and B)
    localparam int unsigned OP_W   = 4;
    // Full product width
    localparam int unsigned PROD_W = 8;

endpackage : wallace_unsigned_multiplier_rca_4_pkg

// File: rtl/wallace_unsigned_multiplier_rca_4_full_adder.sv
// One-bit full adder; also serves as a half adder with cin tied low.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum and majority carry
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule : full_adder

// File: rtl/wallace_unsigned_multiplier_rca_4.sv
// 4x4 unsigned multiplier: AND-array partial products, three-stage Wallace
// reduction to two rows, ripple-carry final adder, registered 8-bit product.
module wallace_unsigned_multiplier_rca_4
    import wallace_unsigned_multiplier_rca_4_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   A,
    input  logic [OP_W-1:0]   B,
    output logic [PROD_W-1:0] product
);

    // pp[i][j] = A[j] & B[i], weight 2^(i+j)
    logic [OP_W-1:0] pp [OP_W];

    // Partial product generation
    always_comb begin
        for (int unsigned i = 0; i < OP_W; i++) begin
            for (int unsigned j = 0; j < OP_W; j++) begin
                pp[i][j] = A[j] & B[i];
            end
        end
    end

    // Column heights before reduction: 1,2,3,4,3,2,1 (columns 0..6).
    // Only columns taller than two bits are reduced in a stage, which takes
    // exactly three stages to bring every column down to at most two bits.

    // ---------------- Stage 1 ----------------
    logic s1_2, c1_3;   // column 2 FA
    logic s1_3, c1_4;   // column 3 FA (pp[3][0] passes through)
    logic s1_4, c1_5;   // column 4 FA

    full_adder u_s1_c2 (
        .a    (pp[0][2]),
        .b    (pp[1][1]),
        .cin  (pp[2][0]),
        .sum  (s1_2),
        .cout (c1_3)
    );

    full_adder u_s1_c3 (
        .a    (pp[0][3]),
        .b    (pp[1][2]),
        .cin  (pp[2][1]),
        .sum  (s1_3),
        .cout (c1_4)
    );

    full_adder u_s1_c4 (
        .a    (pp[1][3]),
        .b    (pp[2][2]),
        .cin  (pp[3][1]),
        .sum  (s1_4),
        .cout (c1_5)
    );

    // ---------------- Stage 2 ----------------
    // Heights now 1,2,1,3,2,3,1
    logic s2_3, c2_4;   // column 3 FA
    logic s2_5, c2_6;   // column 5 FA

    full_adder u_s2_c3 (
        .a    (s1_3),
        .b    (pp[3][0]),
        .cin  (c1_3),
        .sum  (s2_3),
        .cout (c2_4)
    );

    full_adder u_s2_c5 (
        .a    (pp[2][3]),
        .b    (pp[3][2]),
        .cin  (c1_5),
        .sum  (s2_5),
        .cout (c2_6)
    );

    // ---------------- Stage 3 ----------------
    // Heights now 1,2,1,1,3,1,2
    logic s3_4, c3_5;   // column 4 FA

    full_adder u_s3_c4 (
        .a    (s1_4),
        .b    (c1_4),
        .cin  (c2_4),
        .sum  (s3_4),
        .cout (c3_5)
    );

    // ---------------- Final two rows ----------------
    // Heights now 1,2,1,1,1,2,2,0
    logic [PROD_W-1:0] row_x;
    logic [PROD_W-1:0] row_y;

    // Pack the surviving bits into two addend rows
    always_comb begin
        row_x    = '0;
        row_y    = '0;
        row_x[0] = pp[0][0];
        row_x[1] = pp[0][1];
        row_y[1] = pp[1][0];
        row_x[2] = s1_2;
        row_x[3] = s2_3;
        row_x[4] = s3_4;
        row_x[5] = s2_5;
        row_y[5] = c3_5;
        row_x[6] = pp[3][3];
        row_y[6] = c2_6;
    end

    // ---------------- Ripple-carry adder ----------------
    logic [PROD_W-1:0] rca_sum;
    logic [PROD_W-1:0] rca_c;       // rca_c[k] = carry into column k
    logic              rca_cout_unused;  // never set: max product is 225

    assign rca_c[0] = 1'b0;

    full_adder u_rca0 (.a(row_x[0]), .b(row_y[0]), .cin(rca_c[0]), .sum(rca_sum[0]), .cout(rca_c[1]));
    full_adder u_rca1 (.a(row_x[1]), .b(row_y[1]), .cin(rca_c[1]), .sum(rca_sum[1]), .cout(rca_c[2]));
    full_adder u_rca2 (.a(row_x[2]), .b(row_y[2]), .cin(rca_c[2]), .sum(rca_sum[2]), .cout(rca_c[3]));
    full_adder u_rca3 (.a(row_x[3]), .b(row_y[3]), .cin(rca_c[3]), .sum(rca_sum[3]), .cout(rca_c[4]));
    full_adder u_rca4 (.a(row_x[4]), .b(row_y[4]), .cin(rca_c[4]), .sum(rca_sum[4]), .cout(rca_c[5]));
    full_adder u_rca5 (.a(row_x[5]), .b(row_y[5]), .cin(rca_c[5]), .sum(rca_sum[5]), .cout(rca_c[6]));
    full_adder u_rca6 (.a(row_x[6]), .b(row_y[6]), .cin(rca_c[6]), .sum(rca_sum[6]), .cout(rca_c[7]));
    full_adder u_rca7 (.a(row_x[7]), .b(row_y[7]), .cin(rca_c[7]), .sum(rca_sum[7]), .cout(rca_cout_unused));

    // ---------------- Output register ----------------
    logic [PROD_W-1:0] product_d;
    logic [PROD_W-1:0] product_q;

    assign product_d = rca_sum;

    // Capture the product each edge; async reset clears it immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product_q <= '0;
        end else begin
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule : wallace_unsigned_multiplier_rca_4

// File: tb/tb_wallace_unsigned_multiplier_rca_4.sv
// Directed and exhaustive checks for the registered 4x4 Wallace multiplier.
module tb_wallace_unsigned_multiplier_rca_4;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic [7:0] product;

    int n_pass;
    int n_total;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [7];

    wallace_unsigned_multiplier_rca_4 dut (
        .clk     (clk),
        .rst     (rst),
        .A       (A),
        .B       (B),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached (passed %0d of %0d)", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: product=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic edge_sample;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        vecs[0] = '{a: 4'd2,  b: 4'd3,  exp: 8'd6};
        vecs[1] = '{a: 4'd10, b: 4'd3,  exp: 8'd30};
        vecs[2] = '{a: 4'd13, b: 4'd10, exp: 8'd130};
        vecs[3] = '{a: 4'd0,  b: 4'd15, exp: 8'd0};
        vecs[4] = '{a: 4'd15, b: 4'd0,  exp: 8'd0};
        vecs[5] = '{a: 4'd15, b: 4'd15, exp: 8'd225};
        vecs[6] = '{a: 4'd1,  b: 4'd7,  exp: 8'd7};

        // Reset asserted before any clock edge: output must clear at once
        rst = 1'b0;
        A   = 4'd13;
        B   = 4'd10;
        #2;
        rst = 1'b1;
        #1;
        check("reset_immediate", product, 8'd0);
        edge_sample();
        edge_sample();
        check("reset_held", product, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        edge_sample();
        check("reset_release_13x10", product, 8'd130);

        // Directed and boundary table
        foreach (vecs[k]) begin
            @(negedge clk);
            A = vecs[k].a;
            B = vecs[k].b;
            edge_sample();
            check($sformatf("vec%0d_%0dx%0d", k, vecs[k].a, vecs[k].b), product, vecs[k].exp);
        end

        // Latency: inputs change mid-cycle, output holds until the next edge
        @(negedge clk);
        A = 4'd6;
        B = 4'd5;
        #1;
        check("latency_hold", product, 8'd7);
        edge_sample();
        check("latency_update_6x5", product, 8'd30);

        // Mid-operation asynchronous reset pulse between edges
        @(negedge clk);
        A = 4'd9;
        B = 4'd9;
        edge_sample();
        check("stream_9x9", product, 8'd81);
        #1;
        rst = 1'b1;
        #1;
        check("midop_reset_async", product, 8'd0);
        rst = 1'b0;
        #1;
        check("midop_reset_hold", product, 8'd0);
        edge_sample();
        check("midop_release_9x9", product, 8'd81);

        // Exhaustive sweep, one pair per cycle
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [7:0] e;
                e = 8'(a * b);
                @(negedge clk);
                A = 4'(a);
                B = 4'(b);
                edge_sample();
                check($sformatf("exh_%0dx%0d", a, b), product, e);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_wallace_unsigned_multiplier_rca_4
